// File: rtl/byte_instruction_decoder.sv
// Assembles the fetch byte stream (opcode byte plus 0-2 little-endian operand bytes)
// into one decoded instruction handed to execute over a valid/accept handshake.
module byte_instruction_decoder #(
  parameter int width_in    = 8,
  parameter int count_width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_for_decoder,
  input  logic [width_in-1:0]    data_for_decoder,
  output logic                   ready_from_decoder,
  output logic                   instr_valid,
  input  logic                   instr_accept,
  output logic [5:0]             opcode,
  output logic [1:0]             operand_count,
  output logic [15:0]            operand,
  output logic                   illegal,
  output logic [count_width-1:0] issued_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPERAND = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [5:0]             opcode_reg, opcode_next;
  logic [1:0]             count_reg, count_next;
  logic [15:0]            operand_reg, operand_next;
  logic                   idx_reg, idx_next;
  logic                   illegal_reg, illegal_next;
  logic                   ready_reg, ready_next;
  logic                   valid_reg, valid_next;
  logic [count_width-1:0] issued_reg, issued_next;

  logic       byte_xfer;
  logic [1:0] byte_count;

  assign byte_xfer  = start_for_decoder && ready_reg;
  assign byte_count = data_for_decoder[7:6];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      opcode_reg  <= '0;
      count_reg   <= '0;
      operand_reg <= '0;
      idx_reg     <= 1'b0;
      illegal_reg <= 1'b0;
      ready_reg   <= 1'b1;
      valid_reg   <= 1'b0;
      issued_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      opcode_reg  <= opcode_next;
      count_reg   <= count_next;
      operand_reg <= operand_next;
      idx_reg     <= idx_next;
      illegal_reg <= illegal_next;
      ready_reg   <= ready_next;
      valid_reg   <= valid_next;
      issued_reg  <= issued_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    opcode_next  = opcode_reg;
    count_next   = count_reg;
    operand_next = operand_reg;
    idx_next     = idx_reg;
    illegal_next = 1'b0;
    issued_next  = issued_reg;

    unique case (state_reg)
      IDLE: begin
        if (byte_xfer) begin
          if (byte_count == 2'b11) begin
            // Illegal byte is dropped; the last decoded instruction stays visible.
            illegal_next = 1'b1;
          end else begin
            opcode_next  = data_for_decoder[5:0];
            count_next   = byte_count;
            operand_next = '0;
            idx_next     = 1'b0;
            state_next   = (byte_count == 2'b00) ? ISSUE : OPERAND;
          end
        end
      end
      OPERAND: begin
        if (byte_xfer) begin
          if (idx_reg)
            operand_next[15:8] = data_for_decoder[7:0];
          else
            operand_next[7:0]  = data_for_decoder[7:0];
          if (({1'b0, idx_reg} + 2'd1) == count_reg)
            state_next = ISSUE;
          else
            idx_next = 1'b1;
        end
      end
      ISSUE: begin
        if (instr_accept) begin
          issued_next = issued_reg + 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Handshake flags are registered copies of the next state so they change with it.
    ready_next = (state_next != ISSUE);
    valid_next = (state_next == ISSUE);
  end

  assign ready_from_decoder = ready_reg;
  assign instr_valid        = valid_reg;
  assign opcode             = opcode_reg;
  assign operand_count      = count_reg;
  assign operand            = operand_reg;
  assign illegal            = illegal_reg;
  assign issued_count       = issued_reg;

endmodule
